// File: rtl/t05_huff_pkg.sv
// Shared types and constants for the Huffman find-least / tree-builder pair.
// Node IDs are 9 bits wide:
//   char c     = {1'b0, c[7:0]}
//   sum node k = {2'b10, k[6:0]}
//   NULL       = 9'b110000000
package t05_huff_pkg;

  localparam int unsigned FW    = 46;   // frequency / sum width
  localparam int unsigned NCHAR = 256;  // character histogram entries
  localparam int unsigned NSUM  = 128;  // sum nodes, bounded by the 7-bit node counter

  typedef logic [8:0] node_id_t;

  localparam logic       CHAR_TAG  = 1'b0;
  localparam logic [1:0] SUM_TAG   = 2'b10;
  localparam node_id_t   NULL_NODE = 9'b110000000;

  localparam logic [3:0] OP_IDLE   = 4'b0000;
  localparam logic [3:0] OP_FLV    = 4'b0010;
  localparam logic [3:0] OP_HT     = 4'b0011;
  localparam logic [3:0] OP_HTDONE = 4'b0100;
  localparam logic [3:0] OP_ERR    = 4'b1000;

  typedef enum logic [2:0] {StIdle, StReq, StWait, StCmp, StDone, StErr} flv_state_t;

  function automatic node_id_t char_node(input logic [7:0] c);
    return {CHAR_TAG, c};
  endfunction

  function automatic node_id_t sum_node(input logic [6:0] k);
    return {SUM_TAG, k};
  endfunction

endpackage

// File: rtl/t05_least_two_tracker.sv
// Keeps the two smallest non-zero frequencies seen during a scan.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   i_clear         reset both slots to NULL / all-ones (start of a pass)
//   i_upd           offer candidate i_id with frequency i_freq
//   o_nxt*_id/freq  next-state view of the slots, so the parent can register
//                   final results on the same edge as the last update
module t05_least_two_tracker
  import t05_huff_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_upd,
  input  logic [8:0]    i_id,
  input  logic [FW-1:0] i_freq,
  output logic [8:0]    o_nxt1_id,
  output logic [FW-1:0] o_nxt1_freq,
  output logic [8:0]    o_nxt2_id,
  output logic [FW-1:0] o_nxt2_freq
);

  logic [8:0]    r_b1_id, r_b2_id;
  logic [FW-1:0] r_b1_freq, r_b2_freq;

  // Strict less-than keeps the earlier-scanned node on ties.
  always_comb begin
    o_nxt1_id   = r_b1_id;
    o_nxt1_freq = r_b1_freq;
    o_nxt2_id   = r_b2_id;
    o_nxt2_freq = r_b2_freq;
    if (i_clear) begin
      o_nxt1_id   = NULL_NODE;
      o_nxt1_freq = '1;
      o_nxt2_id   = NULL_NODE;
      o_nxt2_freq = '1;
    end else if (i_upd && (i_freq != '0)) begin
      if (i_freq < r_b1_freq) begin
        o_nxt2_id   = r_b1_id;
        o_nxt2_freq = r_b1_freq;
        o_nxt1_id   = i_id;
        o_nxt1_freq = i_freq;
      end else if (i_freq < r_b2_freq) begin
        o_nxt2_id   = i_id;
        o_nxt2_freq = i_freq;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b1_id   <= NULL_NODE;
      r_b1_freq <= '1;
      r_b2_id   <= NULL_NODE;
      r_b2_freq <= '1;
    end else begin
      r_b1_id   <= o_nxt1_id;
      r_b1_freq <= o_nxt1_freq;
      r_b2_id   <= o_nxt2_id;
      r_b2_freq <= o_nxt2_freq;
    end
  end

endmodule

// File: rtl/t05_find_least.sv
// Scans all character frequencies and the sum nodes built so far and reports
// the two least-frequent live nodes plus their combined frequency.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   i_flv_en              pass runs while == OP_FLV
//   i_sum_count           number of sum nodes written so far
//   o_mem_req/o_mem_addr  one-cycle read request for a node ID
//   i_mem_freq/i_mem_valid read response, latency >= 1
//   o_least1/o_least2     result node IDs (NULL when not found)
//   o_sum                 combined frequency, NULL counts as 0
//   o_op_fin              0000 busy/idle, 0010 done, 1000 sum overflow
module t05_find_least
  import t05_huff_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    i_flv_en,
  input  logic [6:0]    i_sum_count,
  output logic          o_mem_req,
  output logic [8:0]    o_mem_addr,
  input  logic [FW-1:0] i_mem_freq,
  input  logic          i_mem_valid,
  output logic [8:0]    o_least1,
  output logic [8:0]    o_least2,
  output logic [FW-1:0] o_sum,
  output logic [3:0]    o_op_fin
);

  flv_state_t       r_state;
  logic [8:0]       r_cursor;
  logic [FW-1:0]    r_freq;
  logic [NCHAR-1:0] r_retired;
  logic             r_mem_req;
  logic [8:0]       r_mem_addr;
  logic [8:0]       r_least1, r_least2;
  logic [FW-1:0]    r_sum;
  logic [3:0]       r_op_fin;

  logic          w_active, w_is_char, w_skip, w_last, w_finish;
  logic [7:0]    w_sum_nxt;
  logic [8:0]    w_next_cursor;
  logic [8:0]    w_nb1_id, w_nb2_id;
  logic [FW-1:0] w_nb1_freq, w_nb2_freq, w_f1, w_f2;
  logic [FW:0]   w_add;

  assign w_active  = (i_flv_en == OP_FLV);
  assign w_is_char = (r_cursor[8] == CHAR_TAG);
  assign w_skip    = w_is_char && r_retired[r_cursor[7:0]];
  assign w_sum_nxt = {1'b0, r_cursor[6:0]} + 8'd1;

  // ">=" rather than "==" so a shrinking sum_count cannot strand the scan.
  assign w_last = w_is_char ? ((r_cursor[7:0] == 8'hff) && (i_sum_count == 7'd0))
                            : (w_sum_nxt >= {1'b0, i_sum_count});

  assign w_next_cursor = !w_is_char              ? sum_node(w_sum_nxt[6:0]) :
                         (r_cursor[7:0] == 8'hff) ? sum_node(7'd0) :
                                                    char_node(r_cursor[7:0] + 8'd1);

  assign w_finish = w_active && w_last &&
                    (((r_state == StReq) && w_skip) || (r_state == StCmp));

  t05_least_two_tracker u_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     ((r_state == StIdle) && w_active),
    .i_upd       ((r_state == StCmp) && w_active),
    .i_id        (r_cursor),
    .i_freq      (r_freq),
    .o_nxt1_id   (w_nb1_id),
    .o_nxt1_freq (w_nb1_freq),
    .o_nxt2_id   (w_nb2_id),
    .o_nxt2_freq (w_nb2_freq)
  );

  // Empty slots hold all-ones as a sentinel; they must add in as zero.
  assign w_f1  = (w_nb1_id == NULL_NODE) ? '0 : w_nb1_freq;
  assign w_f2  = (w_nb2_id == NULL_NODE) ? '0 : w_nb2_freq;
  assign w_add = {1'b0, w_f1} + {1'b0, w_f2};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_cursor   <= '0;
      r_freq     <= '0;
      r_retired  <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_least1   <= NULL_NODE;
      r_least2   <= NULL_NODE;
      r_sum      <= '0;
      r_op_fin   <= OP_IDLE;
    end else begin
      r_mem_req <= 1'b0;
      if (!w_active) begin
        // Abort or idle: results and retire marks are left untouched.
        r_state  <= StIdle;
        r_op_fin <= OP_IDLE;
      end else begin
        unique case (r_state)
          StIdle: begin
            r_cursor <= char_node(8'd0);
            r_state  <= StReq;
          end
          StReq: begin
            if (w_skip) begin
              if (!w_last) r_cursor <= w_next_cursor;
            end else begin
              r_mem_req  <= 1'b1;
              r_mem_addr <= r_cursor;
              r_state    <= StWait;
            end
          end
          StWait: begin
            if (i_mem_valid) begin
              r_freq  <= i_mem_freq;
              r_state <= StCmp;
            end
          end
          StCmp: begin
            if (!w_last) begin
              r_cursor <= w_next_cursor;
              r_state  <= StReq;
            end
          end
          StDone, StErr: r_state <= r_state;
          default:       r_state <= StIdle;
        endcase

        if (w_finish) begin
          if (w_add[FW]) begin
            r_state  <= StErr;
            r_op_fin <= OP_ERR;
          end else begin
            r_state  <= StDone;
            r_op_fin <= OP_FLV;
            r_least1 <= w_nb1_id;
            r_least2 <= w_nb2_id;
            r_sum    <= w_add[FW-1:0];
            if (w_nb1_id[8] == CHAR_TAG) r_retired[w_nb1_id[7:0]] <= 1'b1;
            if (w_nb2_id[8] == CHAR_TAG) r_retired[w_nb2_id[7:0]] <= 1'b1;
          end
        end
      end
    end
  end

  assign o_mem_req  = r_mem_req;
  assign o_mem_addr = r_mem_addr;
  assign o_least1   = r_least1;
  assign o_least2   = r_least2;
  assign o_sum      = r_sum;
  assign o_op_fin   = r_op_fin;

endmodule

// File: tb/tb_t05_find_least.sv
// Bench for t05_find_least: node memory with random read latency, and a
// scoreboard of expected pass results checked when op_fin reports completion.
module tb_t05_find_least;
  import t05_huff_pkg::*;

  logic          clk, rst_n;
  logic [3:0]    flv_en;
  logic [6:0]    sum_count;
  logic          mem_req, mem_valid;
  logic [8:0]    mem_addr, least1, least2;
  logic [FW-1:0] mem_freq, sum;
  logic [3:0]    op_fin;

  logic          auto_valid, man_valid, tb_auto;
  logic [FW-1:0] auto_freq, man_freq;
  logic [FW-1:0] chars [256];
  logic [FW-1:0] sums  [128];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [8:0]    l1;
    logic [8:0]    l2;
    logic [FW-1:0] s;
    logic [3:0]    fin;
    bit            chk_out;
  } exp_t;
  exp_t sb_q[$];

  assign mem_valid = auto_valid | man_valid;
  assign mem_freq  = man_valid ? man_freq : auto_freq;

  t05_find_least u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flv_en    (flv_en),
    .i_sum_count (sum_count),
    .o_mem_req   (mem_req),
    .o_mem_addr  (mem_addr),
    .i_mem_freq  (mem_freq),
    .i_mem_valid (mem_valid),
    .o_least1    (least1),
    .o_least2    (least2),
    .o_sum       (sum),
    .o_op_fin    (op_fin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [FW-1:0] mem_lookup(input logic [8:0] a);
    if (a[8] == 1'b0) return chars[a[7:0]];
    if (a[7] == 1'b0) return sums[a[6:0]];
    return '0;
  endfunction

  // Memory responder: 1..3 cycle latency.
  initial begin
    logic [8:0] addr;
    int unsigned lat;
    auto_valid = 1'b0;
    auto_freq  = '0;
    forever begin
      @(posedge clk); #1;
      if (tb_auto && mem_req) begin
        addr = mem_addr;
        lat  = $urandom_range(1, 3);
        repeat (lat - 1) begin @(posedge clk); #1; end
        auto_freq  = mem_lookup(addr);
        auto_valid = 1'b1;
        @(posedge clk); #1;
        auto_valid = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Push the expectation, run one pass, compare on completion, then release.
  task automatic run_pass(input string tag, input logic [8:0] l1, input logic [8:0] l2,
                          input logic [FW-1:0] s, input logic [3:0] fin, input bit chk_out);
    exp_t e;
    bit   done;
    e.l1 = l1; e.l2 = l2; e.s = s; e.fin = fin; e.chk_out = chk_out;
    sb_q.push_back(e);
    flv_en = OP_FLV;
    done   = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      tick();
      if (op_fin != OP_IDLE) begin
        done = 1'b1;
        break;
      end
    end
    check_eq({tag, "_done"}, 64'(done), 64'd1);
    e = sb_q.pop_front();
    check_eq({tag, "_opfin"}, 64'(op_fin), 64'(e.fin));
    if (e.chk_out) begin
      check_eq({tag, "_least1"}, 64'(least1), 64'(e.l1));
      check_eq({tag, "_least2"}, 64'(least2), 64'(e.l2));
      check_eq({tag, "_sum"}, 64'(sum), 64'(e.s));
    end
    tick();
    check_eq({tag, "_hold"}, 64'(op_fin), 64'(e.fin));
    flv_en = 4'b0000;
    tick();
    check_eq({tag, "_release"}, 64'(op_fin), 64'(OP_IDLE));
  endtask

  localparam logic [8:0] IdA = 9'h061, IdB = 9'h062, IdC = 9'h063, IdD = 9'h064;
  localparam logic [8:0] IdE = 9'h065, IdX = 9'h078, IdY = 9'h079, IdZ = 9'h07a;
  localparam logic [8:0] IdS0 = 9'h100;

  initial begin
    bit seen;
    rst_n     = 1'b0;
    flv_en    = 4'b0000;
    sum_count = 7'd0;
    tb_auto   = 1'b1;
    man_valid = 1'b0;
    man_freq  = '0;
    for (int i = 0; i < 256; i++) chars[i] = '0;
    for (int i = 0; i < 128; i++) sums[i] = '0;

    repeat (3) tick();
    check_eq("rst_least1", 64'(least1), 64'(NULL_NODE));
    check_eq("rst_least2", 64'(least2), 64'(NULL_NODE));
    check_eq("rst_sum", 64'(sum), 64'd0);
    check_eq("rst_opfin", 64'(op_fin), 64'd0);
    check_eq("rst_memreq", 64'(mem_req), 64'd0);
    check_eq("rst_memaddr", 64'(mem_addr), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic pass: b=3, a=5, c=9
    chars[8'h61] = 46'd5; chars[8'h62] = 46'd3; chars[8'h63] = 46'd9;
    run_pass("p1", IdB, IdA, 46'd8, OP_FLV, 1'b1);

    // a,b retired; sum node 0 (8) beats c (9)
    sums[0] = 46'd8; sum_count = 7'd1;
    run_pass("p2", IdS0, IdC, 46'd17, OP_FLV, 1'b1);

    // Sum node 0 consumed; only z live (a,b,c still in memory but retired)
    sums[0] = '0; chars[8'h7a] = 46'd4;
    run_pass("p3", IdZ, NULL_NODE, 46'd4, OP_FLV, 1'b1);
    run_pass("p4", NULL_NODE, NULL_NODE, 46'd0, OP_FLV, 1'b1);

    // Tie order: chars before sums, lower index first
    chars[8'h78] = 46'd2; chars[8'h79] = 46'd2; sums[0] = 46'd2;
    run_pass("p5", IdX, IdY, 46'd4, OP_FLV, 1'b1);

    // Overflow: 2^45 + 2^45 does not fit in FW bits
    sums[0] = '0;
    chars[8'h70] = 46'h2000_0000_0000; chars[8'h71] = 46'h2000_0000_0000;
    run_pass("p6ovf", NULL_NODE, NULL_NODE, 46'd0, OP_ERR, 1'b0);
    chars[8'h70] = '0; chars[8'h71] = '0;

    // Abort during WAIT, then a late mem_valid while idle
    chars[8'h64] = 46'd7; chars[8'h65] = 46'd6;
    tb_auto = 1'b0;
    flv_en  = OP_FLV;
    seen    = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("abort_req_seen", 64'(seen), 64'd1);
    flv_en = 4'b0000;
    tick();
    check_eq("abort_opfin", 64'(op_fin), 64'd0);
    tick();
    man_freq = 46'd1; man_valid = 1'b1;
    tick();
    man_valid = 1'b0;
    tick();
    check_eq("abort_least1", 64'(least1), 64'(IdX));
    check_eq("abort_least2", 64'(least2), 64'(IdY));
    check_eq("abort_sum", 64'(sum), 64'd4);
    tb_auto = 1'b1;
    repeat (2) tick();
    run_pass("p7", IdE, IdD, 46'd13, OP_FLV, 1'b1);

    // Async reset mid-scan clears outputs and the retire mask
    sum_count = 7'd0;
    flv_en    = OP_FLV;
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_least1", 64'(least1), 64'(NULL_NODE));
    check_eq("mid_rst_least2", 64'(least2), 64'(NULL_NODE));
    check_eq("mid_rst_sum", 64'(sum), 64'd0);
    check_eq("mid_rst_opfin", 64'(op_fin), 64'd0);
    check_eq("mid_rst_memreq", 64'(mem_req), 64'd0);
    check_eq("mid_rst_memaddr", 64'(mem_addr), 64'd0);
    flv_en = 4'b0000;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    // All chars live again: x=y=2 are the smallest
    run_pass("p8", IdX, IdY, 46'd4, OP_FLV, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/t05_find_least.md
Name: t05_find_least

Overview:
- Upstream neighbour of the Huffman tree builder.
- On each enabled pass it scans all 256 character frequencies and all sum nodes created so far, then presents the two least-frequent live nodes and their combined frequency.
- Character nodes it returns are retired in an internal mask. Sum nodes are retired when the tree builder writes them back with frequency 0.

Parameters:
- NCHAR, 256, character histogram entries.
- NSUM, 128, maximum sum nodes; must match the 7-bit node counter.
- FW, 46, frequency/sum width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flv_en  in  4  controller enable; pass active while == 4'b0010
- sum_count  in  7  number of sum nodes written so far (tree builder clkCount)
- mem_req  out  1  read request, one-cycle pulse
- mem_addr  out  9  node ID to read (node encoding below)
- mem_freq  in  FW  frequency of requested node (chars zero-extended)
- mem_valid  in  1  read data valid, arbitrary latency >= 1
- least1  out  9  least-frequency node ID
- least2  out  9  second-least node ID
- sum  out  FW  least1 freq + least2 freq
- op_fin  out  4  0000 busy/idle, 0010 done, 1000 error

Behaviour:
- Node encoding:
  - char c = {1'b0, c[7:0]}.
  - sum node k = {2'b10, k[6:0]}.
  - NULL = 9'b110000000.
- Reset values:
  - least1 = least2 = NULL, sum = 0, op_fin = 0, mem_req = 0, mem_addr = 0.
  - Char-retired mask all 0; state IDLE.
- States: IDLE, REQ, WAIT, CMP, DONE, ERR.
- IDLE:
  - On flv_en == 0010: clear best1/best2 to NULL with freq all-ones.
  - Set cursor = char 0, go to REQ.
- REQ:
  - Retired chars are skipped with no read (cursor advances, stay in REQ).
  - Otherwise: mem_req = 1 for one cycle, mem_addr = cursor, go to WAIT.
- WAIT: hold until mem_valid, latch mem_freq, go to CMP.
- CMP:
  - freq == 0 means absent; ignore it.
  - Else if freq < best1: best2 <= best1, best1 <= cur.
  - Else if freq < best2: best2 <= cur.
  - Strict less-than, so on ties the earlier-scanned node wins (chars before sums, lower index first).
  - Advance cursor: char 255 goes to sum 0; when sum index == sum_count, scan ends and go to DONE.
  - If sum_count == 0, the scan ends after char 255.
- DONE, outputs registered on entry:
  - least1/least2 = best IDs (NULL if not found).
  - sum = f1 + f2, where a NULL contributes 0.
  - Char IDs among the results are marked retired.
  - op_fin = 0010; hold while flv_en == 0010.
- Adder carry-out (sum overflow FW bits) -> ERR. ERR holds op_fin = 1000 until flv_en changes.
- flv_en leaving 0010 in any state:
  - Return to IDLE next cycle; op_fin = 0.
  - least/sum outputs keep their last values; retire marks from a completed DONE are kept.
  - Aborted pass: no retire and no output update.
  - A read in flight is discarded: a mem_valid arriving outside WAIT is ignored.
- Outputs change only on DONE entry, so they are stable for the tree builder throughout its pass.
- Latency: one pass ≈ (live nodes read × (mem latency + 2)) + skipped nodes + 2 cycles.
- Async reset mid-pass: immediate return to reset values, including the retired mask (new file).

Decomposition:
- Package t05_huff_pkg holds the node-ID typedef (9-bit), the NULL_NODE, SUM_TAG and CHAR_TAG constants, the op_fin codes (OP_FLV=0010, OP_HT=0011, OP_HTDONE=0100, OP_ERR=1000), and the FW localparam.
- The tree builder shares this package.
- One sub-module: t05_least_two_tracker, holding the best1/best2 registers and the compare/insert logic, with a clear input.

Test Plan:
- Chars 'a'=5, 'b'=3, 'c'=9, others 0, sum_count=0 -> least1=0_01100010, least2=0_01100001, sum=8, op_fin=0010; 'a' and 'b' retired.
- Second pass on the same data plus sum node 0 with freq 8 (sum_count=1) -> least1=0_01100011 (9)? No: sum node 0 (8) < 'c' (9), so least1=10_0000000, least2=0_01100011, sum=17.
- Single live char 'z'=4 -> least1=0_01111010, least2=NULL, sum=4. Next pass -> both NULL, sum=0.
- Tie 'x'=2, 'y'=2, sum node 0 freq 2 -> least1='x', least2='y'; tie order holds.
- Two freqs of 2^45 -> sum overflows -> op_fin=1000. Dropping flv_en to 0 -> op_fin=0 the next cycle.
- flv_en dropped during WAIT, then a late mem_valid -> ignored; the new pass reruns cleanly with outputs and retire mask unchanged. Asserting rst_n low mid-scan -> all outputs return to reset values asynchronously.
